rst_sequencer: RTL
==================

# rst_sequencer

Power-up and recovery reset controller that releases a set of downstream reset domains one after another, in a fixed order, once the clock source is locked. It sits in the always-on clock domain, next to the PLL. Each `o_rst[k]` output drives the async input of that domain's reset bridge, so every domain still gets async assertion and sync de-assertion in its own clock. The sequencer also handles loss of PLL lock and software-requested resets by re-asserting every domain and re-running the sequence.

## Interface
- `N_STAGES`, default 4: number of reset domains (1..16).
- `DELAY_W`, default 16: width of the shared delay counter.
- `STAGE_DELAY`, default 1000: cycles between successive releases (≥1, <2^DELAY_W).
- `HOLD_CYCLES`, default 64: minimum cycles all resets stay asserted after re-assertion (≥1, <2^DELAY_W).
- `LOCK_FILT_W`, default 8: width of the lock-stability filter counter (used only with the filter macro).

Ports:
- `i_clk`  in  1  always-on clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_pll_locked`  in  1  PLL lock, asynchronous; synchronized internally by 2 FFs.
- `i_sw_rst`  in  1  synchronous one-cycle request to re-run the sequence.
- `o_rst`  out  N_STAGES  per-domain reset request, active-high; bit 0 is released first.
- `o_busy`  out  1  high whenever the sequencer is not in RUN.
- `o_done`  out  1  high only in RUN (all domains released).

## Operation
- The FSM has four states: ASSERT, WAIT_LOCK, RELEASE, RUN.
- During `i_rst`:
  - state is ASSERT.
  - `o_rst` is all ones; `o_busy`=1; `o_done`=0.
  - the counter is loaded with HOLD_CYCLES-1.
  - the synchronizer and filter are cleared.
- ASSERT:
  - `o_rst` is all ones.
  - The counter decrements; when it reaches 0, go to WAIT_LOCK.
- WAIT_LOCK:
  - `o_rst` is all ones.
  - When the qualified lock (`lock_q`) is high, load the counter with STAGE_DELAY-1, clear the stage index k, and go to RELEASE.
- RELEASE:
  - The counter decrements.
  - When the counter is 0: clear `o_rst[k]`; if k==N_STAGES-1 go to RUN, else k++ and reload the counter with STAGE_DELAY-1.
  - Released bits stay low.
- RUN: `o_rst` is all zeros; the FSM holds until a fault occurs.
- Fault handling (highest priority, applies in any state):
  - Triggers: `i_sw_rst`=1, or the synchronized lock is low while in RELEASE or RUN.
  - Response: next cycle all `o_rst` bits are high, state is ASSERT, counter is reloaded with HOLD_CYCLES-1.
  - `i_sw_rst` while already in ASSERT restarts the hold count.
  - Lock loss in ASSERT or WAIT_LOCK only blocks progress out of WAIT_LOCK.
- Simultaneous sw_rst and lock loss: a single ASSERT entry.
- `o_rst`, `o_busy`, `o_done` are registered outputs with no combinational path from the inputs.

## Timing
- Lock synchronizer latency: 2 cycles from an `i_pll_locked` edge to the synchronized lock.
- Let T be the first cycle in RELEASE.
  - `o_rst[k]` falls at the edge ending cycle T+(k+1)·STAGE_DELAY-1.
  - `o_done` rises and `o_busy` falls on the same edge as the last `o_rst` bit falls.
- ASSERT lasts exactly HOLD_CYCLES cycles.
- WAIT_LOCK→RELEASE happens one cycle after `lock_q` is seen high.
- Fault→ASSERT: all `o_rst` bits are high 1 cycle after the sampled fault (or 3 cycles after `i_pll_locked` falls); `o_done` drops on the same edge.
- `i_rst` asserted mid-sequence: outputs go to reset values immediately (async); the sequence restarts from ASSERT after de-assertion.

## Configuration
- `RST_SEQ_LOCK_FILTER_EN` defined:
  - `lock_q` goes high only after the synchronized lock has been continuously high for 2^LOCK_FILT_W cycles.
  - Any low sample clears the filter counter.
- Not defined: `lock_q` equals the synchronized lock, and LOCK_FILT_W is unused.
- Lock-loss detection in RELEASE/RUN always uses the unfiltered synchronized lock.

## Test plan
All scenarios use N_STAGES=3, STAGE_DELAY=4, HOLD_CYCLES=8, macro undefined unless stated.
- Power-up with lock already high → `o_rst`=3'b111 for 8 (ASSERT) + 1 (WAIT_LOCK) cycles, then bits clear at T+3, T+7, T+11; `o_done`=1 from T+11.
- Lock held low for 50 cycles after reset → `o_rst` stays 3'b111 and `o_busy`=1; release starts 3 cycles after lock rises.
- Lock drops in RUN → `o_rst`=3'b111 3 cycles later, `o_done`=0, hold of 8 cycles, then the full sequence repeats.
- `i_sw_rst` pulse during RELEASE after bit 0 is released → `o_rst`=3'b111 next cycle; a second pulse 5 cycles later extends ASSERT to 8 cycles past the second pulse.
- `i_rst` asserted mid-RELEASE → `o_rst`=3'b111 and `o_done`=0 immediately (asynchronously), sequence restarts after `i_rst` de-asserts.
- Macro defined, LOCK_FILT_W=4, lock glitch low for 1 cycle at cycle 10 of the filter → no release until 16 consecutive high cycles after the glitch.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: releases N_STAGES reset domains in order once the PLL is locked.
// Optional lock-stability filter enabled by defining RST_SEQ_LOCK_FILTER_EN.
module rst_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int DELAY_W     = 16,
    parameter int STAGE_DELAY = 1000,
    parameter int HOLD_CYCLES = 64,
    parameter int LOCK_FILT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pll_locked,
    input  logic                i_sw_rst,
    output logic [N_STAGES-1:0] o_rst,
    output logic                o_busy,
    output logic                o_done
);

    localparam int STAGE_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [DELAY_W-1:0] HOLD_LOAD  = DELAY_W'(HOLD_CYCLES - 1);
    localparam logic [DELAY_W-1:0] STAGE_LOAD = DELAY_W'(STAGE_DELAY - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t               state_reg, state_next;
    logic [DELAY_W-1:0]   cnt_reg, cnt_next;
    logic [STAGE_W-1:0]   stage_reg, stage_next;
    logic [N_STAGES-1:0]  rst_reg, rst_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [1:0]           sync_reg;
    logic                 lock_sync;
    logic                 lock_q;
    logic                 fault;
    logic [N_STAGES-1:0]  stage_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], i_pll_locked};
        end
    end

    assign lock_sync = sync_reg[1];

`ifdef RST_SEQ_LOCK_FILTER_EN
    logic [LOCK_FILT_W-1:0] filt_cnt_reg;
    logic                   lock_q_reg;

    // Qualified lock rises only after 2^LOCK_FILT_W consecutive high samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            filt_cnt_reg <= '0;
            lock_q_reg   <= 1'b0;
        end else if (!lock_sync) begin
            filt_cnt_reg <= '0;
            lock_q_reg   <= 1'b0;
        end else if (&filt_cnt_reg) begin
            lock_q_reg   <= 1'b1;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    assign lock_q = lock_q_reg;
`else
    // Filter width is irrelevant here; both arms pass the synchronized lock straight through.
    generate
        if (LOCK_FILT_W > 0) begin : g_lock_direct
            assign lock_q = lock_sync;
        end else begin : g_lock_direct_w0
            assign lock_q = lock_sync;
        end
    endgenerate
`endif

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage_hit
            assign stage_hit[gi] = (stage_reg == STAGE_W'(gi));
        end
    endgenerate

    // Lock loss only matters once domains are being released.
    assign fault = i_sw_rst |
                   (~lock_sync & ((state_reg == ST_RELEASE) | (state_reg == ST_RUN)));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stage_next = stage_reg;
        rst_next   = rst_reg;

        case (state_reg)
            ST_ASSERT: begin
                rst_next = '1;
                if (cnt_reg == '0) begin
                    state_next = ST_WAIT_LOCK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                rst_next = '1;
                if (lock_q) begin
                    cnt_next   = STAGE_LOAD;
                    stage_next = '0;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (cnt_reg == '0) begin
                    rst_next = rst_reg & ~stage_hit;
                    if (stage_reg == LAST_STAGE) begin
                        state_next = ST_RUN;
                    end else begin
                        stage_next = stage_reg + 1'b1;
                        cnt_next   = STAGE_LOAD;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RUN: begin
                rst_next = '0;
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = HOLD_LOAD;
                rst_next   = '1;
            end
        endcase

        if (fault) begin
            state_next = ST_ASSERT;
            cnt_next   = HOLD_LOAD;
            stage_next = '0;
            rst_next   = '1;
        end

        busy_next = (state_next != ST_RUN);
        done_next = (state_next == ST_RUN);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_ASSERT;
            cnt_reg   <= HOLD_LOAD;
            stage_reg <= '0;
            rst_reg   <= '1;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stage_reg <= stage_next;
            rst_reg   <= rst_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign o_rst  = rst_reg;
    assign o_busy = busy_reg;
    assign o_done = done_reg;

endmodule
